// File: rtl/mac_unit_pkg.sv
// Shared definitions for the MAC instruction-class datapath: core configuration
// record and the Funct3 sub-op encodings.
package mac_unit_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t CVW_RV32 = '{XLEN: 32};
  localparam cvw_t CVW_RV64 = '{XLEN: 64};

  localparam logic [2:0] MAC_OP_MAC = 3'b000;
  localparam logic [2:0] MAC_OP_CLR = 3'b001;
  localparam logic [2:0] MAC_OP_RD  = 3'b010;
  localparam logic [2:0] MAC_OP_WR  = 3'b011;

endpackage

// File: rtl/mac_datapath.sv
// Combinational Memory-stage MAC arithmetic: signed multiply, accumulate,
// RV64 word narrowing and signed-overflow detection.
module mac_datapath
  import mac_unit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] acc,
  input  logic [2:0]      funct3,
  input  logic            w64,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] rd_value,
  output logic            ovf_set,
  output logic            ovf_clr
);

  localparam logic HAS_W = (XLEN == 64);

  logic            narrow;
  logic [31:0]     prod32;
  logic [31:0]     sum32;
  logic [XLEN-1:0] prod_x;
  logic [XLEN-1:0] sum_x;
  logic [XLEN-1:0] prod;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] src_a_n;
  logic            ovf_add;

  always_comb begin
    narrow = HAS_W && w64;
    // Low product bits are identical for signed and unsigned operands.
    prod32 = src_a[31:0] * src_b[31:0];
    sum32  = acc[31:0] + prod32;
    prod_x = src_a * src_b;
    sum_x  = acc + prod_x;

    if (narrow) begin
      prod          = {XLEN{prod32[31]}};
      prod[31:0]    = prod32;
      sum           = {XLEN{sum32[31]}};
      sum[31:0]     = sum32;
      src_a_n       = {XLEN{src_a[31]}};
      src_a_n[31:0] = src_a[31:0];
      ovf_add       = (acc[31] == prod32[31]) && (sum32[31] != acc[31]);
    end else begin
      prod    = prod_x;
      sum     = sum_x;
      src_a_n = src_a;
      ovf_add = (acc[XLEN-1] == prod_x[XLEN-1]) && (sum_x[XLEN-1] != acc[XLEN-1]);
    end

    acc_next = acc;
    rd_value = acc;
    ovf_set  = 1'b0;
    ovf_clr  = 1'b0;
    unique case (funct3)
      MAC_OP_MAC: begin
        acc_next = sum;
        rd_value = sum;
        ovf_set  = ovf_add;
      end
      MAC_OP_CLR: begin
        acc_next = prod;
        rd_value = prod;
        ovf_clr  = 1'b1;
      end
      MAC_OP_RD: begin
        rd_value = acc;
      end
      MAC_OP_WR: begin
        acc_next = src_a_n;
        rd_value = acc;
        ovf_clr  = 1'b1;
      end
      default: begin
        acc_next = acc;
        rd_value = acc;
      end
    endcase
  end

endmodule

// File: rtl/mac_unit.sv
// MAC instruction-class unit: E->M operand register, architectural accumulator,
// sticky overflow flag and Writeback result register under hazard-unit control.
module mac_unit
  import mac_unit_pkg::*;
#(
  parameter cvw_t P = CVW_RV64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [P.XLEN-1:0]  ForwardedSrcAE,
  input  logic [P.XLEN-1:0]  ForwardedSrcBE,
  input  logic [2:0]         Funct3E,
  input  logic               W64E,
  input  logic               mac_validE,
  input  logic               StallM,
  input  logic               StallW,
  input  logic               FlushM,
  input  logic               FlushW,
  output logic [P.XLEN-1:0]  MACResultW,
  output logic               AccOvf
);

  localparam int unsigned XLEN = P.XLEN;

  logic            valid_m_q,  valid_m_d;
  logic [XLEN-1:0] src_a_m_q,  src_a_m_d;
  logic [XLEN-1:0] src_b_m_q,  src_b_m_d;
  logic [2:0]      funct3_m_q, funct3_m_d;
  logic            w64_m_q,    w64_m_d;
  logic [XLEN-1:0] acc_q,      acc_d;
  logic            acc_ovf_q,  acc_ovf_d;
  logic [XLEN-1:0] result_w_q, result_w_d;

  logic            commit;
  logic [XLEN-1:0] acc_next;
  logic [XLEN-1:0] rd_value;
  logic            ovf_set;
  logic            ovf_clr;

  mac_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .src_a    (src_a_m_q),
    .src_b    (src_b_m_q),
    .acc      (acc_q),
    .funct3   (funct3_m_q),
    .w64      (w64_m_q),
    .acc_next (acc_next),
    .rd_value (rd_value),
    .ovf_set  (ovf_set),
    .ovf_clr  (ovf_clr)
  );

  always_comb begin
    valid_m_d  = valid_m_q;
    src_a_m_d  = src_a_m_q;
    src_b_m_d  = src_b_m_q;
    funct3_m_d = funct3_m_q;
    w64_m_d    = w64_m_q;
    if (!StallM) begin
      valid_m_d  = mac_validE & ~FlushM;
      src_a_m_d  = ForwardedSrcAE;
      src_b_m_d  = ForwardedSrcBE;
      funct3_m_d = Funct3E;
      w64_m_d    = W64E;
    end

    // acc is read combinationally in M, so a MAC entering M sees the value
    // committed on that same edge without any bypass path.
    commit     = valid_m_q & ~StallW & ~FlushW;
    acc_d      = acc_q;
    acc_ovf_d  = acc_ovf_q;
    result_w_d = result_w_q;
    if (commit) begin
      acc_d      = acc_next;
      acc_ovf_d  = (acc_ovf_q | ovf_set) & ~ovf_clr;
      result_w_d = rd_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_m_q  <= 1'b0;
      src_a_m_q  <= '0;
      src_b_m_q  <= '0;
      funct3_m_q <= '0;
      w64_m_q    <= 1'b0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      result_w_q <= '0;
    end else begin
      valid_m_q  <= valid_m_d;
      src_a_m_q  <= src_a_m_d;
      src_b_m_q  <= src_b_m_d;
      funct3_m_q <= funct3_m_d;
      w64_m_q    <= w64_m_d;
      acc_q      <= acc_d;
      acc_ovf_q  <= acc_ovf_d;
      result_w_q <= result_w_d;
    end
  end

  assign MACResultW = result_w_q;
  assign AccOvf     = acc_ovf_q;

endmodule

// File: tb/tb_mac_unit.sv
// Lockstep bench for mac_unit at XLEN=32 and XLEN=64 against a transaction-level
// arithmetic reference model; directed plan followed by randomized traffic.
module tb_mac_unit;
  import mac_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] srca, srcb;
  logic [2:0]  f3;
  logic        w64, v_e, st_m, st_w, fl_m, fl_w;
  logic [31:0] res32;
  logic [63:0] res64;
  logic        ovf32, ovf64;

  always #5 clk = ~clk;

  mac_unit #(.P(CVW_RV32)) dut32 (
    .clk(clk), .reset(reset),
    .ForwardedSrcAE(srca[31:0]), .ForwardedSrcBE(srcb[31:0]),
    .Funct3E(f3), .W64E(w64), .mac_validE(v_e),
    .StallM(st_m), .StallW(st_w), .FlushM(fl_m), .FlushW(fl_w),
    .MACResultW(res32), .AccOvf(ovf32)
  );

  mac_unit #(.P(CVW_RV64)) dut64 (
    .clk(clk), .reset(reset),
    .ForwardedSrcAE(srca), .ForwardedSrcBE(srcb),
    .Funct3E(f3), .W64E(w64), .mac_validE(v_e),
    .StallM(st_m), .StallW(st_w), .FlushM(fl_m), .FlushW(fl_w),
    .MACResultW(res64), .AccOvf(ovf64)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference state: architectural acc/flag per width, the instruction
  // waiting in M, and the expected Writeback value with its valid bit.
  logic        m_v;
  logic [2:0]  m_op;
  logic [63:0] m_a, m_b;
  logic        m_w;
  logic [63:0] acc32_m, acc64_m, r32_m, r64_m;
  logic        ovf32_m, ovf64_m, wv;

  function automatic logic signed [127:0] sx(input logic [127:0] v, input int unsigned w);
    logic signed [127:0] t;
    t = v << (128 - w);
    return t >>> (128 - w);
  endfunction

  function automatic logic [63:0] trunc(input logic [127:0] v, input int unsigned xlen);
    logic [63:0] r;
    r = v[63:0];
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [63:0] exec(input int unsigned xlen, input logic [2:0] op,
                                       input logic [63:0] a, input logic [63:0] b, input logic w,
                                       inout logic [63:0] acc, inout logic ovf);
    int unsigned wd;
    logic signed [127:0] as_, bs, acs, p, s;
    logic [63:0] rd;
    wd  = (xlen == 64 && w) ? 32 : xlen;
    as_ = sx({64'd0, a}, wd);
    bs  = sx({64'd0, b}, wd);
    acs = sx({64'd0, acc}, wd);
    p   = sx(as_ * bs, wd);
    rd  = acc;
    case (op)
      3'd0: begin
        s   = acs + p;
        if (s != sx(s, wd)) ovf = 1'b1;
        acc = trunc(sx(s, wd), xlen);
        rd  = acc;
      end
      3'd1: begin acc = trunc(p, xlen); ovf = 1'b0; rd = acc; end
      3'd2: rd = acc;
      3'd3: begin rd = acc; acc = trunc(as_, xlen); ovf = 1'b0; end
      default: rd = acc;
    endcase
    return rd;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic w, input logic sm, input logic sw,
                      input logic fm, input logic fw);
    v_e = v; f3 = op; srca = a; srcb = b; w64 = w;
    st_m = sm; st_w = sw; fl_m = fm; fl_w = fw;
    @(posedge clk);
    if (reset) begin
      m_v = 1'b0; acc32_m = '0; acc64_m = '0; ovf32_m = 1'b0; ovf64_m = 1'b0;
      r32_m = '0; r64_m = '0; wv = 1'b0;
    end else begin
      if (m_v && !sw && !fw) begin
        r32_m = exec(32, m_op, m_a, m_b, m_w, acc32_m, ovf32_m);
        r64_m = exec(64, m_op, m_a, m_b, m_w, acc64_m, ovf64_m);
        wv = 1'b1;
      end else if (!sw) begin
        wv = 1'b0;
      end
      if (!sm) begin
        m_v = v && !fm; m_op = op; m_a = a; m_b = b; m_w = w;
      end
    end
    #1;
    chk("ovf32", {63'd0, ovf32}, {63'd0, ovf32_m});
    chk("ovf64", {63'd0, ovf64}, {63'd0, ovf64_m});
    if (wv) begin
      chk("res32", {32'd0, res32}, r32_m);
      chk("res64", res64, r64_m);
    end
  endtask

  task automatic op1(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic w);
    step(1'b1, op, a, b, w, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h0000_0000_7FFF_FFFF;
      4: return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic sm, sw, fm, fw;
    m_v = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_w = 1'b0; wv = 1'b0;
    acc32_m = '0; acc64_m = '0; ovf32_m = 1'b0; ovf64_m = 1'b0; r32_m = '0; r64_m = '0;

    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
    chk("reset_res32", {32'd0, res32}, 64'd0);
    chk("reset_res64", res64, 64'd0);

    op1(MAC_OP_RD, 0, 0, 0); idle();
    chk("accrd_after_reset", {32'd0, res32}, 64'd0);

    op1(MAC_OP_CLR, 3, 4, 0); op1(MAC_OP_MAC, 5, 6, 0);
    chk("macclr_12", {32'd0, res32}, 64'd12);
    idle();
    chk("mac_b2b_42", {32'd0, res32}, 64'd42);
    op1(MAC_OP_RD, 0, 0, 0); idle();
    chk("accrd_42", res64, 64'd42);

    op1(MAC_OP_WR, 64'h7FFF_FFFF, 0, 0); op1(MAC_OP_MAC, 1, 1, 0);
    chk("accwr_old_acc", {32'd0, res32}, 64'd42);
    idle();
    chk("ovf_wrap", {32'd0, res32}, 64'h8000_0000);
    chk("ovf_set", {63'd0, ovf32}, 64'd1);
    op1(MAC_OP_MAC, 1, 1, 0); idle();
    chk("ovf_sticky", {63'd0, ovf32}, 64'd1);
    op1(MAC_OP_CLR, 0, 0, 0); idle();
    chk("ovf_clear", {63'd0, ovf32}, 64'd0);

    op1(MAC_OP_WR, 42, 0, 0); idle();
    op1(MAC_OP_MAC, 2, 3, 0);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    op1(MAC_OP_RD, 0, 0, 0); idle();
    chk("flushw_acc_kept", {32'd0, res32}, 64'd42);

    op1(MAC_OP_RD, 0, 0, 0); op1(MAC_OP_MAC, 7, 7, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("stallw_res_stable", {32'd0, res32}, 64'd42);
    end
    idle();
    chk("stallw_commit", {32'd0, res32}, 64'd91);
    idle(); op1(MAC_OP_RD, 0, 0, 0); idle();
    chk("stallw_once", res64, 64'd91);

    op1(MAC_OP_MAC, 9, 9, 0);
    reset = 1'b1; idle(); reset = 1'b0;
    op1(MAC_OP_RD, 0, 0, 0); idle();
    chk("reset_discards", res64, 64'd0);

    op1(MAC_OP_WR, 64'h7FFF_FFFF, 0, 1); op1(MAC_OP_MAC, 1, 1, 1); idle();
    chk("w64_sext", res64, 64'hFFFF_FFFF_8000_0000);
    chk("w64_ovf", {63'd0, ovf64}, 64'd1);
    op1(MAC_OP_WR, 64'h7FFF_FFFF, 0, 0); op1(MAC_OP_MAC, 1, 1, 0); idle();
    chk("d64_noext", res64, 64'h0000_0000_8000_0000);
    chk("d64_noovf", {63'd0, ovf64}, 64'd0);

    for (int unsigned i = 0; i < 400; i++) begin
      sw = ($urandom_range(0, 7) == 0);
      sm = sw | ($urandom_range(0, 9) == 0);
      fm = !sm && ($urandom_range(0, 11) == 0);
      fw = !sw && ($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), rnd_operand(),
           rnd_operand(), 1'($urandom_range(0, 1)), sm, sw, fm, fw);
    end
    idle(); idle();
    op1(MAC_OP_RD, 0, 0, 0); idle();
    chk("final_acc32", {32'd0, res32}, acc32_m);
    chk("final_acc64", res64, acc64_m);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
